rgmii_tx_ddr_gen: RTL
=====================

Name: rgmii_tx_ddr_gen

Overview:
Multi-channel RGMII transmit-side DDR pattern generator. It is the parametrised successor of the single-port RGMII TX path.
- Per channel: produces registered d1/d2 (rising/falling half) values for TXC, TD[3:0] and TX_CTL, to drive external ODDR instances.
- Generates the MAC clock-enable strobe.
- Adds configurable 10M/100M divide ratios, an optional byte-to-nibble mode, and glitch-free speed switching deferred to frame idle.
- Sits between up to CHANNELS GMII MACs and their ODDR/pad wrappers, all on one gtx clock.

Parameters:
CHANNELS, 1, number of independent TX channels (1..16).
CLK_DIV_100M, 5, clk cycles per TXC period at 100M (2..63).
CLK_DIV_10M, 50, clk cycles per TXC period at 10M (2..63).
BYTE_MODE, 0, 1 = at 10/100 the MAC supplies full bytes; the block sends low nibble then high nibble.

Ports:
clk  input  1  gtx clock, 125 MHz; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
speed  input  2*CHANNELS  per-channel requested speed: 2'b10 = 1G, 2'b01 = 100M, 2'b00 = 10M, 2'b11 is treated as 1G.
gmii_txd  input  8*CHANNELS  per-channel TX data.
gmii_tx_en  input  CHANNELS  per-channel TX enable.
gmii_tx_er  input  CHANNELS  per-channel TX error.
gmii_tx_clk_en  output  CHANNELS  MAC clock enable; MAC advances data only when high.
speed_active  output  2*CHANNELS  speed currently in effect per channel.
txc_d1, txc_d2  output  CHANNELS  TXC ODDR inputs (d1 = first half of clk, d2 = second half).
txd_d1, txd_d2  output  4*CHANNELS  TD ODDR inputs.
tx_ctl_d1, tx_ctl_d2  output  CHANNELS  TX_CTL ODDR inputs.
err_clr  input  CHANNELS  clears speed_err (optional feature only).
speed_err  output  CHANNELS  sticky speed-change-during-frame flag (optional feature only).

Behaviour:
- Channels are fully independent. Each has a 6-bit counter cnt, an active speed register, a nibble phase bit and a state {RUN, PEND}. All outputs are registered.
- Reset values (rst low, asynchronous):
  - cnt = 0, nibble phase = 0, state RUN, speed_active = 2'b10.
  - gmii_tx_clk_en = 1, txc_d1 = 1, txc_d2 = 0.
  - txd_d1/d2 = 0, tx_ctl_d1/d2 = 0, speed_err = 0.
- Release of reset is sampled on the first rising clk edge with rst high.
- 1G mode:
  - txc_d1 = 1, txc_d2 = 0, gmii_tx_clk_en = 1 every cycle.
  - txd_d1 = txd[3:0], txd_d2 = txd[7:4].
  - tx_ctl_d1 = en, tx_ctl_d2 = en ^ er.
  - Latency from GMII inputs to outputs: 1 clk.
- 10/100 modes, with D = CLK_DIV_10M or CLK_DIV_100M:
  - cnt runs 0..D-1 and wraps to 0.
  - txc_d1 = (2*cnt >= D), txc_d2 = (2*cnt+1 >= D). This gives exactly 50% duty in half-cycles, including for odd D.
  - gmii_tx_clk_en is high for exactly one cycle, registered when cnt == D-1, so it is visible in the cycle where cnt == 0.
  - TD and TX_CTL inputs are captured into holding registers in the cycle where gmii_tx_clk_en is high. The outputs hold them for the full TXC period; txd_d1 = txd_d2.
  - tx_ctl_dX = txc_dX ? (en ^ er) : en, applied per half-cycle.
- BYTE_MODE = 1 at 10/100:
  - gmii_tx_clk_en is asserted only every second TXC period, i.e. one strobe per 2*D cycles.
  - The period following capture sends byte[3:0] (phase 0); the next period sends byte[7:4] (phase 1).
  - en/er are held for both periods.
- BYTE_MODE = 0: the low nibble only, every period.
- Speed switching:
  - If speed differs from speed_active, the state goes to PEND.
  - PEND commits the new speed on the first cycle where all of these hold:
    - the channel is at a period boundary (cnt == D-1 and, in BYTE_MODE, phase 1; any cycle when in 1G);
    - the held tx_en is 0;
    - gmii_tx_en is 0.
  - On commit: cnt = 0, phase = 0, state RUN, and the next cycle emits the new-speed pattern from its start.
  - If the request reverts to the active speed while in PEND, return to RUN with no disturbance.
  - TXC never produces a high or low pulse shorter than min(D_old, D_new) half-cycles.
- Simultaneous strobe and commit: the commit wins. The strobe is not issued; the first strobe at the new speed follows the normal rules.
- Reset mid-frame: all state returns to reset values immediately; no output glitch beyond the asynchronous clear.

Optional Feature:
RGMII_TX_SPEED_ERR_EN
- Defined:
  - speed_err[i] is set on any cycle where the speed request changes while the channel is in a frame (held tx_en = 1 or gmii_tx_en = 1).
  - It stays set until err_clr[i] is high on a clock edge. If set and clear occur together, set wins.
- Not defined:
  - speed_err is constant 0 and err_clr is ignored.
  - No extra registers are inferred.

Test Plan:
- Reset, CHANNELS=1, speed=2'b10, txd=8'hA5, en=1, er=0 → next cycle: txd_d1=4'h5, txd_d2=4'hA, tx_ctl_d1=1, tx_ctl_d2=1, txc_d1/d2=1/0, clk_en=1 continuously.
- speed=2'b01, D=5, after commit → txc_d1/d2 sequence per cycle 00,00,01,11,11 repeating; clk_en high 1 cycle in every 5; en=1, er=1 → tx_ctl low half=1, high half=0.
- BYTE_MODE=1, 10M, D=50, byte 8'h3C → 50 cycles of txd=4'hC then 50 cycles of 4'h3; clk_en period 100 cycles.
- Mid-frame request 1G→100M with en=1 → speed_active stays 2'b10 until en=0 at a boundary, then becomes 2'b01 with cnt=0; with macro defined, speed_err=1 until err_clr is pulsed.
- CHANNELS=4 at mixed speeds {1G, 100M, 10M, 100M} → each channel's strobe period is 1/5/50/5 cycles, with no cross-channel interaction.
- Assert rst low mid-period at 10M with cnt=37 → outputs return to reset values asynchronously; after release, speed_active=2'b10, then PEND→commit to 10M at the first idle cycle.

Source files
------------

// File: rtl/rgmii_tx_ddr_gen.sv
// Multi-channel RGMII transmit DDR pattern generator producing per-channel ODDR d1/d2 inputs.
// Optional sticky speed-change error flag enabled by defining RGMII_TX_SPEED_ERR_EN.
module rgmii_tx_ddr_gen #(
    parameter int CHANNELS     = 1,
    parameter int CLK_DIV_100M = 5,
    parameter int CLK_DIV_10M  = 50,
    parameter int BYTE_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] speed,
    input  logic [8*CHANNELS-1:0] gmii_txd,
    input  logic [CHANNELS-1:0]   gmii_tx_en,
    input  logic [CHANNELS-1:0]   gmii_tx_er,
    output logic [CHANNELS-1:0]   gmii_tx_clk_en,
    output logic [2*CHANNELS-1:0] speed_active,
    output logic [CHANNELS-1:0]   txc_d1,
    output logic [CHANNELS-1:0]   txc_d2,
    output logic [4*CHANNELS-1:0] txd_d1,
    output logic [4*CHANNELS-1:0] txd_d2,
    output logic [CHANNELS-1:0]   tx_ctl_d1,
    output logic [CHANNELS-1:0]   tx_ctl_d2,
    input  logic [CHANNELS-1:0]   err_clr,
    output logic [CHANNELS-1:0]   speed_err
);
    typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_t;

    localparam logic [5:0] DIV_100M = 6'(CLK_DIV_100M);
    localparam logic [5:0] DIV_10M  = 6'(CLK_DIV_10M);
    localparam logic       BYTE_EN  = (BYTE_MODE != 0);

`ifndef RGMII_TX_SPEED_ERR_EN
    logic unused_err_clr_s;
    assign unused_err_clr_s = ^err_clr;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t     state_r, state_nx_s;
        logic [5:0] cnt_r, cnt_nx_s, div_s, div_nx_s;
        logic [1:0] spd_r, spd_nx_s, req_s;
        logic       phase_r, phase_nx_s;
        logic       hold_en_r, hold_en_nx_s, hold_er_r, hold_er_nx_s;
        logic [3:0] hold_hi_r, hold_hi_nx_s;
        logic       clk_en_r, clk_en_nx_s;
        logic       txc1_r, txc1_nx_s, txc2_r, txc2_nx_s;
        logic [3:0] txd1_r, txd1_nx_s, txd2_r, txd2_nx_s;
        logic       ctl1_r, ctl1_nx_s, ctl2_r, ctl2_nx_s;
        logic [6:0] dbl_s;
        logic       last_s, boundary_s, commit_s;

        // Request decode (2'b11 folds to 1G) and commit qualification at a quiet period boundary
        always_comb begin
            req_s      = speed[2*g+1] ? 2'b10 : speed[2*g +: 2];
            div_s      = (spd_r == 2'b01) ? DIV_100M : DIV_10M;
            last_s     = (cnt_r == (div_s - 6'd1));
            boundary_s = spd_r[1] | (last_s & (~BYTE_EN | phase_r));
            commit_s   = (state_r == ST_PEND) & (req_s != spd_r) & boundary_s
                         & ~hold_en_r & ~gmii_tx_en[g];
        end

        // Speed-switch state machine: RUN until a differing request, PEND until commit or revert
        always_comb begin
            state_nx_s = state_r;
            case (state_r)
                ST_RUN: begin
                    if (req_s != spd_r) state_nx_s = ST_PEND;
                    else                state_nx_s = ST_RUN;
                end
                ST_PEND: begin
                    if (commit_s || (req_s == spd_r)) state_nx_s = ST_RUN;
                    else                              state_nx_s = ST_PEND;
                end
                default: state_nx_s = ST_RUN;
            endcase
        end

        // Next values of counter, holding registers and all registered ODDR outputs
        always_comb begin
            spd_nx_s     = commit_s ? req_s : spd_r;
            div_nx_s     = (spd_nx_s == 2'b01) ? DIV_100M : DIV_10M;
            cnt_nx_s     = cnt_r;
            phase_nx_s   = phase_r;
            clk_en_nx_s  = clk_en_r;
            hold_en_nx_s = hold_en_r;
            hold_er_nx_s = hold_er_r;
            hold_hi_nx_s = hold_hi_r;
            txd1_nx_s    = txd1_r;
            txd2_nx_s    = txd2_r;
            txc1_nx_s    = txc1_r;
            txc2_nx_s    = txc2_r;
            ctl1_nx_s    = ctl1_r;
            ctl2_nx_s    = ctl2_r;
            dbl_s        = 7'd0;
            if (spd_nx_s[1]) begin
                cnt_nx_s     = 6'd0;
                phase_nx_s   = 1'b0;
                clk_en_nx_s  = 1'b1;
                hold_en_nx_s = gmii_tx_en[g];
                hold_er_nx_s = gmii_tx_er[g];
                hold_hi_nx_s = gmii_txd[8*g+4 +: 4];
                txd1_nx_s    = gmii_txd[8*g +: 4];
                txd2_nx_s    = gmii_txd[8*g+4 +: 4];
                txc1_nx_s    = 1'b1;
                txc2_nx_s    = 1'b0;
                ctl1_nx_s    = gmii_tx_en[g];
                ctl2_nx_s    = gmii_tx_en[g] ^ gmii_tx_er[g];
            end else begin
                if (commit_s) begin
                    // Fresh start at the new rate; a strobe due on this edge is dropped
                    cnt_nx_s     = 6'd0;
                    phase_nx_s   = 1'b0;
                    clk_en_nx_s  = 1'b0;
                    hold_en_nx_s = 1'b0;
                    hold_er_nx_s = 1'b0;
                    txd1_nx_s    = 4'd0;
                    txd2_nx_s    = 4'd0;
                end else begin
                    cnt_nx_s    = last_s ? 6'd0 : (cnt_r + 6'd1);
                    phase_nx_s  = BYTE_EN & (phase_r ^ last_s);
                    clk_en_nx_s = last_s & (~BYTE_EN | phase_r);
                    if (clk_en_r) begin
                        hold_en_nx_s = gmii_tx_en[g];
                        hold_er_nx_s = gmii_tx_er[g];
                        hold_hi_nx_s = gmii_txd[8*g+4 +: 4];
                        txd1_nx_s    = gmii_txd[8*g +: 4];
                        txd2_nx_s    = gmii_txd[8*g +: 4];
                    end else if (BYTE_EN && (cnt_r == 6'd0) && phase_r) begin
                        txd1_nx_s = hold_hi_r;
                        txd2_nx_s = hold_hi_r;
                    end else begin
                        txd1_nx_s = txd1_r;
                        txd2_nx_s = txd2_r;
                    end
                end
                // Half-cycle compare gives 50% duty for odd divisors too
                dbl_s     = {cnt_nx_s, 1'b0};
                txc1_nx_s = (dbl_s >= {1'b0, div_nx_s});
                txc2_nx_s = ((dbl_s + 7'd1) >= {1'b0, div_nx_s});
                ctl1_nx_s = txc1_nx_s ? (hold_en_nx_s ^ hold_er_nx_s) : hold_en_nx_s;
                ctl2_nx_s = txc2_nx_s ? (hold_en_nx_s ^ hold_er_nx_s) : hold_en_nx_s;
            end
        end

        // Channel state and output registers
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_r   <= ST_RUN;
                cnt_r     <= 6'd0;
                spd_r     <= 2'b10;
                phase_r   <= 1'b0;
                hold_en_r <= 1'b0;
                hold_er_r <= 1'b0;
                hold_hi_r <= 4'd0;
                clk_en_r  <= 1'b1;
                txc1_r    <= 1'b1;
                txc2_r    <= 1'b0;
                txd1_r    <= 4'd0;
                txd2_r    <= 4'd0;
                ctl1_r    <= 1'b0;
                ctl2_r    <= 1'b0;
            end else begin
                state_r   <= state_nx_s;
                cnt_r     <= cnt_nx_s;
                spd_r     <= spd_nx_s;
                phase_r   <= phase_nx_s;
                hold_en_r <= hold_en_nx_s;
                hold_er_r <= hold_er_nx_s;
                hold_hi_r <= hold_hi_nx_s;
                clk_en_r  <= clk_en_nx_s;
                txc1_r    <= txc1_nx_s;
                txc2_r    <= txc2_nx_s;
                txd1_r    <= txd1_nx_s;
                txd2_r    <= txd2_nx_s;
                ctl1_r    <= ctl1_nx_s;
                ctl2_r    <= ctl2_nx_s;
            end
        end

        assign gmii_tx_clk_en[g]      = clk_en_r;
        assign speed_active[2*g +: 2] = spd_r;
        assign txc_d1[g]              = txc1_r;
        assign txc_d2[g]              = txc2_r;
        assign txd_d1[4*g +: 4]       = txd1_r;
        assign txd_d2[4*g +: 4]       = txd2_r;
        assign tx_ctl_d1[g]           = ctl1_r;
        assign tx_ctl_d2[g]           = ctl2_r;

`ifdef RGMII_TX_SPEED_ERR_EN
        logic [1:0] req_prev_r;
        logic       err_r;
        logic       err_set_s;

        // A request change while a frame is in flight raises the error
        always_comb begin
            err_set_s = (req_s != req_prev_r) & (hold_en_r | gmii_tx_en[g]);
        end

        // Sticky error flag; set dominates clear
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                req_prev_r <= 2'b10;
                err_r      <= 1'b0;
            end else begin
                req_prev_r <= req_s;
                if (err_set_s)       err_r <= 1'b1;
                else if (err_clr[g]) err_r <= 1'b0;
                else                 err_r <= err_r;
            end
        end

        assign speed_err[g] = err_r;
`else
        assign speed_err[g] = 1'b0;
`endif
    end
endmodule
